// File: rtl/burst_responder.sv
// Target-side burst responder: fixed-latency start/size request,
// then a valid/ready stream of address/data beats and a done pulse.
module burst_responder #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int SIZE_W  = 8,
   parameter int LATENCY = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [SIZE_W-1:0] size,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              ready,
   output logic              valid,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BURST,
      DONE
   } state_t;

   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   state_t            state;
   logic [7:0]        cnt;
   logic [SIZE_W-1:0] len;
   logic [ADDR_W-1:0] base;
   logic [SIZE_W-1:0] idx;
   logic [SIZE_W-1:0] nidx;

   assign nidx = idx + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         len     <= '0;
         base    <= '0;
         idx     <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         address <= '0;
         data    <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               done  <= 1'b0;
               state <= IDLE;
               if (start) begin
                  len  <= size;
                  base <= start_addr;
                  idx  <= '0;
                  cnt  <= LAT_M1;
                  busy <= 1'b1;
                  // The first beat is registered one edge before its cycle,
                  // so a single-cycle latency skips WAIT entirely.
                  if (LATENCY == 1 && size != '0) begin
                     state   <= BURST;
                     valid   <= 1'b1;
                     address <= start_addr;
                     data    <= '0;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (len == '0 && cnt == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (len != '0 && cnt == 8'd1) begin
                  state   <= BURST;
                  valid   <= 1'b1;
                  address <= base;
                  data    <= '0;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            BURST: begin
               if (ready) begin
                  if (nidx == len) begin
                     state <= DONE;
                     valid <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     idx     <= nidx;
                     address <= base + ADDR_W'(nidx);
                     data    <= DATA_W'(nidx);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_burst_responder.sv
// Scoreboard bench for burst_responder: stimulus pushes expected beats
// and done times; a negedge monitor pops and compares.
module tb_burst_responder;

   localparam int L  = 10;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int SW = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [SW-1:0] size;
   logic [AW-1:0] start_addr;
   logic          ready;
   logic          valid;
   logic [AW-1:0] address;
   logic [DW-1:0] data;
   logic          busy;
   logic          done;

   burst_responder #(
      .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .LATENCY(L)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .size(size),
      .start_addr(start_addr), .ready(ready), .valid(valid),
      .address(address), .data(data), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            first;
      bit            last;
   } beat_t;

   beat_t beatq[$];
   int    doneq[$];
   int    checks = 0;
   int    fails = 0;
   bit    mon_en = 1'b0;
   bit    rand_ready = 1'b0;
   bit    held = 1'b0;
   bit    prev_valid = 1'b0;
   logic [AW-1:0] h_a;
   logic [DW-1:0] h_d;
   int    last_done = -1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      fails++;
      $display("FAIL %s: timeout (cyc %0d)", name, cyc);
   endtask

   // Reference: beat i of a request carries base+i and i, first beat
   // LATENCY cycles after the start cycle; size 0 only pulses done.
   task automatic issue(input int sz, input int addr);
      beat_t b;
      int n;
      n = cyc;
      start = 1'b1;
      size = SW'(sz);
      start_addr = AW'(addr);
      for (int i = 0; i < sz; i++) begin
         b.a = AW'(addr + i);
         b.d = DW'(i);
         b.first = (i == 0) ? n + L : -1;
         b.last = (i == sz - 1);
         beatq.push_back(b);
      end
      if (sz == 0) doneq.push_back(n + L + 1);
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         @(posedge clock);
         #1;
         if (!busy) return;
      end
      bound_fail("wait_idle");
   endtask

   task automatic drain();
      for (int i = 0; i < 3000; i++) begin
         @(posedge clock);
         #1;
         if (beatq.size() == 0 && doneq.size() == 0) return;
      end
      bound_fail("drain");
   endtask

   always @(posedge clock)
      if (rand_ready) #1 ready = ($urandom_range(0, 3) != 0);

   always @(negedge clock) begin
      beat_t b;
      if (mon_en) begin
         if (doneq.size() > 0 && doneq[0] == cyc) begin
            chk("done_pulse", {31'd0, done}, 1);
            chk("busy_in_done", {31'd0, busy}, 0);
            last_done = cyc;
            void'(doneq.pop_front());
         end else if (done) begin
            chk("unexpected_done", {31'd0, done}, 0);
         end
         if (held) begin
            chk("stall_valid", {31'd0, valid}, 1);
            chk("stall_addr", {16'd0, address}, {16'd0, h_a});
            chk("stall_data", {24'd0, data}, {24'd0, h_d});
         end
         held = 1'b0;
         if (valid) begin
            chk("busy_in_burst", {31'd0, busy}, 1);
            if (!prev_valid && beatq.size() > 0 && beatq[0].first >= 0)
               chk("first_valid_cyc", cyc, beatq[0].first);
         end
         if (valid && ready) begin
            if (beatq.size() == 0) begin
               chk("extra_beat", {31'd0, valid}, 0);
            end else begin
               b = beatq.pop_front();
               chk("beat_addr", {16'd0, address}, {16'd0, b.a});
               chk("beat_data", {24'd0, data}, {24'd0, b.d});
               if (b.last) doneq.push_back(cyc + 1);
            end
         end else if (valid) begin
            held = 1'b1;
            h_a = address;
            h_d = data;
         end
         prev_valid = valid;
      end
   end

   initial begin
      int n;
      int sz;
      bit hit;
      reset = 1'b1;
      start = 1'b0;
      size = '0;
      start_addr = '0;
      ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_valid", {31'd0, valid}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_addr", {16'd0, address}, 0);
      chk("rst_data", {24'd0, data}, 0);
      reset = 1'b0;
      ready = 1'b1;
      mon_en = 1'b1;

      // basic burst with busy window
      @(posedge clock);
      #1 n = cyc;
      issue(4, 16'h0100);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clock);
         chk("busy_t1", {31'd0, busy}, (k <= 13) ? 1 : 0);
      end
      drain();
      chk("done_t1", last_done, n + 14);

      // ready low on 2nd and 3rd valid cycles
      wait_idle();
      n = cyc;
      issue(4, 16'h0100);
      while (cyc < n + 11) begin
         @(posedge clock);
         #1;
      end
      ready = 1'b0;
      @(posedge clock);
      #1;
      @(posedge clock);
      #1 ready = 1'b1;
      drain();
      chk("done_stall", last_done, n + 16);

      // zero-size request
      wait_idle();
      n = cyc;
      issue(0, 16'h1234);
      for (int k = 1; k <= 11; k++) begin
         @(negedge clock);
         chk("busy_sz0", {31'd0, busy}, (k <= 10) ? 1 : 0);
      end
      drain();
      chk("done_sz0", last_done, n + 11);

      // address wrap
      wait_idle();
      issue(4, 16'hFFFE);
      drain();

      // start while busy ignored, start in DONE accepted
      wait_idle();
      n = cyc;
      issue(3, 16'h0200);
      while (cyc < n + 5) begin
         @(posedge clock);
         #1;
      end
      start = 1'b1;
      size = 8'd7;
      start_addr = 16'h5555;
      @(posedge clock);
      #1 start = 1'b0;
      wait_idle();
      chk("in_done_cycle", {31'd0, done}, 1);
      issue(2, 16'h0300);
      drain();

      // reset during beat 2 of 8
      wait_idle();
      issue(8, 16'h0400);
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(posedge clock);
         #1;
         if (valid && address == 16'h0402) hit = 1'b1;
      end
      if (!hit) bound_fail("reach_beat2");
      reset = 1'b1;
      @(posedge clock);
      #1 mon_en = 1'b0;
      reset = 1'b0;
      beatq.delete();
      doneq.delete();
      @(negedge clock);
      chk("mid_rst_valid", {31'd0, valid}, 0);
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_done", {31'd0, done}, 0);
      chk("mid_rst_addr", {16'd0, address}, 0);
      chk("mid_rst_data", {24'd0, data}, 0);
      held = 1'b0;
      prev_valid = 1'b0;
      #1 mon_en = 1'b1;
      @(posedge clock);
      #1;
      issue(3, 16'h0600);
      drain();

      // randomized traffic with random ready
      rand_ready = 1'b1;
      for (int t = 0; t < 40; t++) begin
         wait_idle();
         repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
         end
         sz = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
         if (t == 20) sz = 255;
         issue(sz, int'($urandom_range(0, 16'hFFFF)));
         if (sz > 0 && $urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(0, 12)) begin
               @(posedge clock);
               #1;
            end
            if (busy) begin
               start = 1'b1;
               size = SW'($urandom_range(0, 255));
               start_addr = AW'($urandom_range(0, 16'hFFFF));
               @(posedge clock);
               #1 start = 1'b0;
            end
         end
      end
      drain();
      rand_ready = 1'b0;
      repeat (5) @(posedge clock);
      chk("beats_left", beatq.size(), 0);
      chk("dones_left", doneq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
